// File: rtl/reg_fifo_pkg.sv
// reg_fifo_pkg: shared constants (flag reset values), clog2 helper and parameter-legality check for reg_fifo_param
package reg_fifo_pkg;
  localparam logic FF_RST = 1'b0;
  localparam logic EF_RST = 1'b0;
  localparam logic AF_RST = 1'b0;
  localparam logic AE_RST = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
  function automatic bit params_ok(input int width, input int depth, input int addr, input int af, input int ae);
    return width >= 1 && depth >= 2 && depth == (1 << addr) && clog2(depth) == addr &&
           af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_flag_gen.sv
// fifo_flag_gen: registers Count/FF/EF/AF/AE from next-state pointers (in: Clock, Reset, wptr_nx, rptr_nx; out: Count, FF, EF, AF, AE)
module fifo_flag_gen
  import reg_fifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR     = 4,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [ADDR:0]   wptr_nx,
  input  logic [ADDR:0]   rptr_nx,
  output logic [ADDR:0]   Count,
  output logic            FF,
  output logic            EF,
  output logic            AF,
  output logic            AE
);
  localparam logic [ADDR:0] FULL_C = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR:0] AF_C   = (ADDR + 1)'(AF_LEVEL);
  localparam logic [ADDR:0] AE_C   = (ADDR + 1)'(AE_LEVEL);
  logic [ADDR:0] cnt;
  assign cnt = wptr_nx - rptr_nx;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Count <= '0;
      FF    <= FF_RST;
      EF    <= EF_RST;
      AF    <= AF_RST;
      AE    <= AE_RST;
    end else begin
      Count <= cnt;
      FF    <= cnt == FULL_C;
      EF    <= cnt != '0;
      AF    <= cnt >= AF_C;
      AE    <= cnt <= AE_C;
    end
  end
endmodule

// File: rtl/reg_fifo_param.sv
// reg_fifo_param: register FIFO (Clock, Reset, Data/WE in; RE in, Q out; FF/EF/AF/AE/Count flags; OVF/UDF pulses), FWFT via REG_FIFO_PARAM_FWFT_EN
module reg_fifo_param
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR     = 4,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             WE,
  input  logic             RE,
  output logic [WIDTH-1:0] Q,
  output logic             FF,
  output logic             EF,
  output logic             AF,
  output logic             AE,
  output logic [ADDR:0]    Count,
  output logic             OVF,
  output logic             UDF
);
  if (!params_ok(WIDTH, DEPTH, ADDR, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("reg_fifo_param: illegal parameter combination");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR:0] wptr, rptr, wptr_nx, rptr_nx;
  logic rd_acc, wr_acc;
  logic [ADDR-1:0] ra;
  assign rd_acc  = RE & EF;
  assign wr_acc  = WE & (~FF | rd_acc);
  assign wptr_nx = wptr + {{ADDR{1'b0}}, wr_acc};
  assign rptr_nx = rptr + {{ADDR{1'b0}}, rd_acc};
  assign ra      = rptr[ADDR-1:0];
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr <= '0;
      rptr <= '0;
      OVF  <= 1'b0;
      UDF  <= 1'b0;
    end else begin
      wptr <= wptr_nx;
      rptr <= rptr_nx;
      OVF  <= WE & ~wr_acc;
      UDF  <= RE & ~rd_acc;
    end
  end
  always_ff @(posedge Clock)
    if (!Reset && wr_acc) mem[wptr[ADDR-1:0]] <= Data;
`ifdef REG_FIFO_PARAM_FWFT_EN
  logic [WIDTH-1:0] q_hold;
  always_ff @(posedge Clock) q_hold <= Reset ? '0 : EF ? mem[ra] : q_hold;
  assign Q = EF ? mem[ra] : q_hold;
`else
  always_ff @(posedge Clock) Q <= Reset ? '0 : rd_acc ? mem[ra] : Q;
`endif
  fifo_flag_gen #(
    .DEPTH(DEPTH), .ADDR(ADDR), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) u_flags (
    .Clock(Clock), .Reset(Reset), .wptr_nx(wptr_nx), .rptr_nx(rptr_nx),
    .Count(Count), .FF(FF), .EF(EF), .AF(AF), .AE(AE)
  );
endmodule

// File: tb/tb_reg_fifo_param.sv
// tb_reg_fifo_param: directed plan plus randomized traffic against a queue-based FIFO model
module tb_reg_fifo_param;
  localparam int W = 8, D = 16, A = 4;
  logic Clock = 1'b0, Reset = 1'b0, WE = 1'b0, RE = 1'b0;
  logic [W-1:0] Data = '0, Q;
  logic FF, EF, AF, AE, OVF, UDF;
  logic [A:0] Count;
  int total = 0, bad = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] q_exp = '0;
  logic ovf_e = 1'b0, udf_e = 1'b0;
  reg_fifo_param #(.WIDTH(W), .DEPTH(D), .ADDR(A), .AF_LEVEL(D - 2), .AE_LEVEL(2)) dut (
    .Clock(Clock), .Reset(Reset), .Data(Data), .WE(WE), .RE(RE), .Q(Q),
    .FF(FF), .EF(EF), .AF(AF), .AE(AE), .Count(Count), .OVF(OVF), .UDF(UDF)
  );
  always #5 Clock = ~Clock;
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic we, input logic re, input logic [W-1:0] d, input logic rst);
    bit rd, wr;
    WE = we; RE = re; Data = d; Reset = rst;
    @(posedge Clock);
    if (rst) begin
      mq.delete();
      q_exp = '0; ovf_e = 0; udf_e = 0;
    end else begin
      rd = re && mq.size() > 0;
      wr = we && (mq.size() < D || rd);
      ovf_e = we && !wr;
      udf_e = re && !rd;
      if (rd) q_exp = mq.pop_front();
      if (wr) mq.push_back(d);
`ifdef REG_FIFO_PARAM_FWFT_EN
      if (mq.size() > 0) q_exp = mq[0];
`endif
    end
    #1;
    chk("count", 32'(Count), 32'(mq.size()));
    chk("ff", 32'(FF), 32'(mq.size() == D));
    chk("ef", 32'(EF), 32'(mq.size() != 0));
    chk("af", 32'(AF), 32'(mq.size() >= D - 2));
    chk("ae", 32'(AE), 32'(mq.size() <= 2));
    chk("ovf", 32'(OVF), 32'(ovf_e));
    chk("udf", 32'(UDF), 32'(udf_e));
    chk("q", 32'(Q), 32'(q_exp));
  endtask
  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < D; i++) step(1, 0, W'(i), 0);
    step(1, 0, 8'hEE, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < D; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < D; i++) step(1, 0, W'(8'h80 + i), 0);
    for (int i = 0; i < 20; i++) step(1, 1, W'(8'h40 + i), 0);
    for (int i = 0; i < D; i++) step(0, 1, 0, 0);
    step(1, 1, 8'hA5, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, W'(8'h20 + i), 0);
    step(1, 0, 8'h77, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 300) % 3;
      step($urandom_range(0, 9) < (ph == 0 ? 8 : ph == 1 ? 2 : 5),
           $urandom_range(0, 9) < (ph == 0 ? 2 : ph == 1 ? 8 : 5),
           W'($urandom), $urandom_range(0, 199) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_fifo_param.md
# reg_fifo_param

Parametrised synchronous register-based FIFO; the next generation of the team's register FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky-free overflow/underflow error pulses. An optional first-word-fall-through read mode is selected at compile time. It sits between producer and consumer logic in a single clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- ADDR, 4, pointer width = log2(DEPTH); must match DEPTH (checked at elaboration)
- AF_LEVEL, DEPTH-2, AF asserts when Count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, AE asserts when Count ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- Clock  input  1  rising-edge clock, sole clock
- Reset  input  1  synchronous, active-high reset, sampled on rising Clock
- Data  input  WIDTH  write data
- WE  input  1  active-high write enable
- RE  input  1  active-high read enable
- Q  output  WIDTH  read data
- FF  output  1  active-high full flag
- EF  output  1  active-low empty flag (0 = empty)
- AF  output  1  active-high almost-full
- AE  output  1  active-high almost-empty
- Count  output  ADDR+1  current occupancy, 0..DEPTH
- OVF  output  1  one-cycle pulse: write rejected
- UDF  output  1  one-cycle pulse: read rejected

## Operation
- Pointers WPtr and RPtr are ADDR+1 bits; low ADDR bits address mem; MSB is the wrap bit. Full = addresses equal and MSBs differ; empty = pointers equal.
- Write accepted when WE && (!full || RE_accepted). Read accepted when RE && !empty.
- Simultaneous WE+RE when full: both accepted, Count unchanged, FF stays 1.
- Simultaneous WE+RE when empty: write accepted, read rejected (UDF pulses). In FWFT mode the same rule applies.
- WE while full without RE: data dropped, pointers unchanged, OVF=1 for one cycle.
- RE while empty: pointers and Q unchanged, UDF=1 for one cycle.
- Count next = Count + wr_acc − rd_acc; never exceeds DEPTH or goes below 0.
- FF, EF, AF, AE, and Count are registered and derived from the next-state count, so all are mutually consistent in every cycle.
- Pointers wrap modulo 2·DEPTH naturally; no special case at DEPTH−1.
- Storage array is not reset; contents are undefined until written.

## Timing
- Reset values: Q=0, FF=0, EF=0 (empty), AF=0 (1 if AF_LEVEL=0 is illegal, so 0), AE=1, Count=0, OVF=0, UDF=0, pointers=0.
- Reset asserted mid-operation empties the FIFO on that edge. WE/RE in the same cycle are ignored.
- Write at edge N: EF=1, Count+1, FF/AF updated after edge N.
- Standard mode read: RE accepted at edge N loads Q with the head word after edge N (1-cycle latency). Q holds between reads.
- OVF/UDF assert after the offending edge and clear on the next edge unless repeated.
- No combinational path from inputs to any output except Q in FWFT mode (see Configuration).

## Configuration
- Macro: REG_FIFO_PARAM_FWFT_EN.
- Defined: first-word-fall-through. Q continuously shows mem[RPtr] whenever EF=1. A word written into an empty FIFO at edge N appears on Q after edge N. RE consumes the displayed word, and Q shows the next word after that edge. When EF=0, Q is don't-care (implementation holds the last value).
- Undefined: standard mode; Q is registered as described in Timing.

## Structure
- Package reg_fifo_pkg: clog2 constant function, reset-value constants for flags, parameter-legality checks.
- One sub-module is natural: fifo_flag_gen. It takes WPtr/RPtr next-state values and the thresholds, and produces registered Count, FF, EF, AF, AE. The top holds the pointers, memory, Q, and OVF/UDF.

## Test plan
- Reset, then 16 writes of 0x00..0x0F (DEPTH=16, no RE) -> Count=16, FF=1, AF=1 from the 14th write, EF=1 after the first write. A 17th write gives OVF=1 for one cycle, and Count stays 16.
- 16 reads after fill -> Q sequence 0x00..0x0F (standard mode: 1 cycle after each RE), EF=0 after the last read, AE=1 once Count ≤ 2. An extra RE gives UDF=1, and Q holds 0x0F.
- Full FIFO plus WE=RE=1 for 20 cycles -> no OVF, Count=16, FF=1 throughout, FIFO order preserved across the pointer wrap.
- Empty FIFO plus WE=RE=1 with Data=0xA5 -> UDF=1, Count=1, EF=1. A next-cycle RE returns 0xA5.
- Reset asserted with Count=9 and WE=1 -> after the edge Count=0, EF=0, AE=1, Q=0, and the written word is discarded.
- FWFT build: a single write of 0x3C into an empty FIFO -> Q=0x3C after the write edge with no RE. RE then gives EF=0 after the edge.
